card_shoe: RTL and testbench

//   Card source for the blackjack game FSM: holds a finite shoe of NUM_DECKS decks and deals one card per request.

---
 rtl/card_shoe.sv | 147 ++++++++++++++
 tb/tb_card_shoe.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/card_shoe.sv
// card_shoe: finite shoe of NUM_DECKS decks that deals one card per request.
// Per-rank remaining counts guarantee no rank is dealt more than 4*NUM_DECKS
// times per shoe; an LFSR picks where the rank search starts.
// Build option: define CARD_SHOE_TEST_EN to take the search start from a
// deterministic rank counter (A,2,..,K,A,..) instead of the LFSR.
module card_shoe #(
    parameter int          NUM_DECKS = 1,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       shuffle,
    input  logic       draw_req,
    output logic       draw_ready,
    output logic       card_valid,
    output logic [3:0] card_rank,
    output logic [3:0] card_value,
    output logic [7:0] cards_left,
    output logic       shuffling
);
    // Count width sized so a rank can hold the full 4*NUM_DECKS copies.
    localparam int            PER_RANK  = 4 * NUM_DECKS;
    localparam int            CW        = $clog2(PER_RANK + 1);
    localparam logic [CW-1:0] RANK_FULL = CW'(PER_RANK);
    localparam logic [7:0]    SHOE_FULL = 8'(52 * NUM_DECKS);
    localparam logic [3:0]    LAST_IDX  = 4'd12;

    typedef enum logic [1:0] {S_IDLE, S_SHUFFLE, S_SEARCH, S_PRESENT} state_t;

    state_t        state_q, state_d;
    logic [3:0]    ptr_q;
    logic [3:0]    idx_q;
    logic [3:0]    rank_q;
    logic [3:0]    value_q;
    logic [15:0]   lfsr_q, lfsr_d;
    logic          pend_q;
    logic [7:0]    left_q;
    logic [CW-1:0] cnt_q [13];
    logic [3:0]    src;
    logic [3:0]    start_idx;
    logic          hit;

    // Galois form of x^16+x^14+x^13+x^11+1, shifting right.
    assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

`ifdef CARD_SHOE_TEST_EN
    logic [3:0] tcnt_q;

    // Deterministic start rank: advances once per dealt card, survives shuffles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tcnt_q <= 4'd0;
        end else if (state_q == S_SEARCH && hit) begin
            tcnt_q <= (tcnt_q == LAST_IDX) ? 4'd0 : tcnt_q + 4'd1;
        end
    end

    assign src = tcnt_q;
`else
    assign src = lfsr_q[3:0];
`endif

    // Fold 13..15 back onto 0..2 so every start index names a real rank.
    assign start_idx = (src >= 4'd13) ? src - 4'd13 : src;
    assign hit       = (cnt_q[idx_q] != '0);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_SHUFFLE;
        else          state_q <= state_d;
    end

    // Next-state: shuffle beats draw in IDLE; an empty shoe turns a draw into a shuffle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (shuffle)               state_d = S_SHUFFLE;
                else if (draw_req)         state_d = (left_q != 8'd0) ? S_SEARCH : S_SHUFFLE;
            end
            S_SHUFFLE: begin
                if (ptr_q == LAST_IDX)     state_d = pend_q ? S_SEARCH : S_IDLE;
            end
            S_SEARCH: begin
                if (hit)                   state_d = S_PRESENT;
            end
            S_PRESENT:                     state_d = S_IDLE;
            default:                       state_d = S_SHUFFLE;
        endcase
    end

    // Outputs decoded from state; rank/value are registered and hold between cards.
    always_comb begin
        draw_ready = (state_q == S_IDLE);
        card_valid = (state_q == S_PRESENT);
        shuffling  = (state_q == S_SHUFFLE);
        card_rank  = rank_q;
        card_value = value_q;
        cards_left = left_q;
    end

    // Shoe datapath: LFSR, reload pointer, probe index, per-rank counts, card latch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q  <= LFSR_SEED;
            ptr_q   <= 4'd0;
            idx_q   <= 4'd0;
            pend_q  <= 1'b0;
            left_q  <= 8'd0;
            rank_q  <= 4'd0;
            value_q <= 4'd0;
            for (int i = 0; i < 13; i++) cnt_q[i] <= '0;
        end else begin
            lfsr_q <= lfsr_d;
            case (state_q)
                S_IDLE: begin
                    if (!shuffle && draw_req) begin
                        idx_q  <= start_idx;
                        pend_q <= (left_q == 8'd0);
                    end
                end
                S_SHUFFLE: begin
                    cnt_q[ptr_q] <= RANK_FULL;
                    if (ptr_q == LAST_IDX) begin
                        ptr_q  <= 4'd0;
                        left_q <= SHOE_FULL;
                        pend_q <= 1'b0;
                        idx_q  <= start_idx;
                    end else begin
                        ptr_q  <= ptr_q + 4'd1;
                    end
                end
                S_SEARCH: begin
                    if (hit) begin
                        cnt_q[idx_q] <= cnt_q[idx_q] - CW'(1);
                        left_q       <= left_q - 8'd1;
                        rank_q       <= idx_q + 4'd1;
                        value_q      <= (idx_q >= 4'd9) ? 4'd10 : idx_q + 4'd1;
                    end else begin
                        idx_q <= (idx_q == LAST_IDX) ? 4'd0 : idx_q + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_card_shoe.sv
// Self-checking bench for card_shoe (NUM_DECKS=1). A cycle-level model of the
// shoe (remaining cards per rank, shuffle/deal timing) is compared with the DUT
// every cycle; directed scenarios add literal expectations on top.
module tb_card_shoe;
    localparam int          ND   = 1;
    localparam logic [15:0] SEED = 16'hACE1;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       shuffle = 1'b0;
    logic       draw_req = 1'b0;
    logic       draw_ready, card_valid, shuffling;
    logic [3:0] card_rank, card_value;
    logic [7:0] cards_left;

    card_shoe #(.NUM_DECKS(ND), .LFSR_SEED(SEED)) dut (
        .clk(clk), .reset_n(reset_n), .shuffle(shuffle), .draw_req(draw_req),
        .draw_ready(draw_ready), .card_valid(card_valid), .card_rank(card_rank),
        .card_value(card_value), .cards_left(cards_left), .shuffling(shuffling)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Model state: shoe contents, shuffle cycles still to run, cycles until the next card.
    int          m_rem [13];
    int          m_left, m_shuf, m_due, m_rank, m_exp, m_tcnt;
    logic [15:0] m_lfsr;

    // Per-cycle snapshots taken at the falling edge.
    int s_ready, s_valid, s_shuf, s_left, s_rank, s_value;
    int hist [13];

    function automatic int val_of(int r);
        return (r >= 10) ? 10 : r;
    endfunction

    task automatic chk(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic m_init();
        for (int i = 0; i < 13; i++) m_rem[i] = 0;
        m_left = 0; m_shuf = 13; m_due = -1; m_rank = 0; m_exp = 0; m_tcnt = 0;
        m_lfsr = SEED;
    endtask

    task automatic model_step();
        int  idle, known, rr, ok, s, k;
        if (!reset_n) begin
            m_init();
            chk("rst_ready", s_ready, 0);
            chk("rst_valid", s_valid, 0);
            chk("rst_shuffling", s_shuf, 1);
            chk("rst_rank", s_rank, 0);
            chk("rst_value", s_value, 0);
            chk("rst_cards_left", s_left, 0);
            return;
        end
        known = 1;
        if (m_due == 0) begin
            if (m_exp != 0) begin
                m_rank = m_exp;
            end else begin
                // card dealt straight after an auto-shuffle: any rank still in the shoe
                known = 0;
                rr = s_rank;
                ok = (rr >= 1 && rr <= 13) ? ((m_rem[rr-1] > 0) ? 1 : 0) : 0;
                chk("auto_rank_in_shoe", ok, 1);
                if (ok != 0) m_rem[rr-1]--;
                m_rank = rr;
            end
            m_left--;
            m_tcnt = (m_tcnt + 1) % 13;
        end
        idle = (m_shuf == 0 && m_due < 0) ? 1 : 0;
        chk("draw_ready", s_ready, idle);
        chk("shuffling", s_shuf, (m_shuf > 0) ? 1 : 0);
        chk("card_valid", s_valid, (m_due == 0) ? 1 : 0);
        chk("cards_left", s_left, m_left);
        if (known != 0) chk("card_rank", s_rank, m_rank);
        chk("card_value", s_value, val_of(m_rank));
        // advance to the next cycle
        if (m_due >= 0) m_due--;
        if (m_shuf > 0) begin
            m_shuf--;
            if (m_shuf == 0) begin
                m_left = 52 * ND;
                for (int i = 0; i < 13; i++) m_rem[i] = 4 * ND;
            end
        end
        if (idle != 0) begin
            if (shuffle) begin
                m_shuf = 13;
            end else if (draw_req) begin
                if (m_left > 0) begin
`ifdef CARD_SHOE_TEST_EN
                    s = m_tcnt;
`else
                    s = int'(m_lfsr[3:0]);
`endif
                    if (s >= 13) s -= 13;
                    k = 0;
                    while (k < 13 && m_rem[(s + k) % 13] == 0) k++;
                    m_exp = (s + k) % 13 + 1;
                    m_rem[m_exp-1]--;
                    m_due = 1 + k;
                end else begin
                    m_shuf = 13;
                    m_due  = 14;
                    m_exp  = 0;
                end
            end
        end
        m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    endtask

    // One clock cycle: sample outputs on the falling edge, check, then drive just after the rising edge.
    task automatic tick();
        @(negedge clk);
        s_ready = int'(draw_ready); s_valid = int'(card_valid); s_shuf = int'(shuffling);
        s_left = int'(cards_left); s_rank = int'(card_rank); s_value = int'(card_value);
        if (reset_n && card_valid && card_rank >= 4'd1 && card_rank <= 4'd13) hist[card_rank-1]++;
        model_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cnt, got, lat, nv, n_target;
        m_init();
        for (int i = 0; i < 13; i++) hist[i] = 0;
        repeat (3) tick();
        reset_n = 1'b1;

        // 1: automatic shuffle out of reset
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (s_shuf != 0) cnt++;
            if (s_ready != 0) break;
        end
        chk("t1_shuffle_cycles", cnt, 13);
        chk("t1_ready", s_ready, 1);
        chk("t1_valid", s_valid, 0);
        chk("t1_cards_left", s_left, 52);
        for (int i = 0; i < 13; i++) hist[i] = 0;

`ifdef CARD_SHOE_TEST_EN
        // 2: deterministic order from a fresh shoe
        for (int i = 0; i < 13; i++) begin
            draw_req = 1'b1;
            tick();
            chk("t2_accept", s_ready, 1);
            draw_req = 1'b0;
            lat = 0; got = 0;
            for (int j = 0; j < 20; j++) begin
                tick(); lat++;
                if (s_valid != 0) begin got = 1; break; end
            end
            chk("t2_valid_seen", got, 1);
            chk("t2_latency", lat, 2);
            chk("t2_rank", s_rank, i + 1);
            chk("t2_value", s_value, (i < 10) ? i + 1 : 10);
        end
        chk("t2_cards_left", int'(cards_left), 39);
`endif

        // 3: drain the shoe with draw_req held high
        n_target = int'(cards_left);
        draw_req = 1'b1;
        got = 0;
        for (int i = 0; i < 1200 && got < n_target; i++) begin
            tick();
            if (s_valid != 0) begin
                got++;
                if (got == n_target) draw_req = 1'b0;
            end
        end
        draw_req = 1'b0;
        chk("t3_draws", got, n_target);
        nv = 0;
        repeat (6) begin tick(); nv += s_valid; end
        chk("t3_extra_valid", nv, 0);
        chk("t3_cards_left", s_left, 0);
        for (int r = 0; r < 13; r++) chk($sformatf("t3_rank%0d_count", r + 1), hist[r], 4);

        // 4: draw from an empty shoe triggers a shuffle then deals
        draw_req = 1'b1;
        tick();
        chk("t4_accept", s_ready, 1);
        draw_req = 1'b0;
        lat = 0; cnt = 0; got = 0;
        for (int i = 0; i < 40; i++) begin
            tick(); lat++;
            if (s_shuf != 0) cnt++;
            if (s_valid != 0) begin got = 1; break; end
        end
        chk("t4_valid_seen", got, 1);
        chk("t4_shuffle_cycles", cnt, 13);
        chk("t4_latency", lat, 15);
        chk("t4_cards_left", s_left, 51);

        // 5: shuffle and draw together - the draw is dropped
        tick();
        shuffle = 1'b1; draw_req = 1'b1;
        tick();
        chk("t5_in_idle", s_ready, 1);
        shuffle = 1'b0; draw_req = 1'b0;
        cnt = 0; nv = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (s_shuf != 0) cnt++;
            nv += s_valid;
            if (s_ready != 0) break;
        end
        chk("t5_valid", nv, 0);
        chk("t5_shuffle_cycles", cnt, 13);
        chk("t5_ready", s_ready, 1);
        chk("t5_cards_left", s_left, 52);

        // 6: reset while searching
        draw_req = 1'b1;
        tick();
        chk("t6_accept", s_ready, 1);
        draw_req = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_valid", int'(card_valid), 0);
        chk("t6_rst_shuffling", int'(shuffling), 1);
        chk("t6_rst_ready", int'(draw_ready), 0);
        chk("t6_rst_rank", int'(card_rank), 0);
        chk("t6_rst_cards_left", int'(cards_left), 0);
        tick(); tick();
        reset_n = 1'b1;
        cnt = 0; nv = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (s_shuf != 0) cnt++;
            nv += s_valid;
            if (s_ready != 0) break;
        end
        chk("t6_valid", nv, 0);
        chk("t6_shuffle_cycles", cnt, 13);
        chk("t6_ready", s_ready, 1);
        chk("t6_cards_left", s_left, 52);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
